// File: rtl/z80_bus_pkg.sv
// Shared types and constants for the Z80 bus master and its helpers.
//   bus_state_e : memory-cycle sequencer states
//   STROBE_OFF  : idle value of {nMREQ, nRD, nWR}
package z80_bus_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned WAIT_W     = 8;
    localparam int unsigned STROBE_W   = 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        TW   = 3'd3,
        T3   = 3'd4
    } bus_state_e;

    // {nMREQ, nRD, nWR} all deasserted
    localparam logic [STROBE_W-1:0] STROBE_OFF = 3'b111;

endpackage

// File: rtl/z80_wait_timer.sv
// Wait-state counter for Z80 bus cycles.
//   clk, rst   : clock, synchronous active-high reset
//   i_clr      : clear count to zero
//   i_en       : increment count
//   o_expired  : count has reached MAX_WAIT
module z80_wait_timer
    import z80_bus_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [WAIT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + WAIT_W'(1);
        end
    end

    assign o_expired = (r_count == WAIT_W'(MAX_WAIT));

endmodule

// File: rtl/z80_bus_master.sv
// Command/response initiator that runs Z80-timed memory cycles
// (T1-T2-Tw-T3) on the CPU-side bus.
//   cmd_*      : command handshake (valid/ready, we, addr, wdata)
//   rsp_*      : one-cycle completion pulse with read data and timeout error
//   bus_*      : address, write data + drive enable, read data
//   nMREQ/nRD/nWR : active-low strobes, nWAIT : active-low wait request
module z80_bus_master
    import z80_bus_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_data_out,
    output logic              bus_data_oe,
    input  logic [DATA_W-1:0] bus_data_in,
    output logic              nMREQ,
    output logic              nRD,
    output logic              nWR,
    input  logic              nWAIT
);

    bus_state_e          r_state;
    bus_state_e          w_next_state;

    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_err;

    logic [STROBE_W-1:0] r_strobe;
    logic                r_oe;
    logic [ADDR_W-1:0]   r_bus_addr;
    logic [DATA_W-1:0]   r_bus_data_out;
    logic                r_rsp_valid;
    logic                r_rsp_err;
    logic [DATA_W-1:0]   r_rsp_rdata;

    logic                w_accept;
    logic                w_expired;
    logic                w_abort;
    logic                w_tmr_clr;
    logic                w_tmr_en;
    logic                w_we;
    logic [ADDR_W-1:0]   w_lat_addr;
    logic [DATA_W-1:0]   w_lat_wdata;
    logic [STROBE_W-1:0] w_strobe;
    logic                w_oe;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_dout;

    assign cmd_ready = (r_state == IDLE) && !rst;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_abort   = (r_state == TW) && !nWAIT && w_expired;

    // Outputs are registered from the next state, so the accepting cycle
    // must forward the command fields that are being latched at that edge.
    assign w_we        = w_accept ? cmd_we    : r_we;
    assign w_lat_addr  = w_accept ? cmd_addr  : r_addr;
    assign w_lat_wdata = w_accept ? cmd_wdata : r_wdata;

    // Counter is zero entering T2; first low nWAIT sample loads 1
    assign w_tmr_clr = (r_state != T2) && (r_state != TW);
    assign w_tmr_en  = !nWAIT && ((r_state == T2) || ((r_state == TW) && !w_expired));

    z80_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_tmr_clr),
        .i_en      (w_tmr_en),
        .o_expired (w_expired)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next_state = T1;
            T1:   w_next_state = T2;
            T2:   w_next_state = nWAIT ? T3 : TW;
            TW:   if (nWAIT || w_expired) w_next_state = T3;
            T3:   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Bus output values for the upcoming state; address and data hold in IDLE
    always_comb begin
        w_strobe = STROBE_OFF;
        w_oe     = 1'b0;
        w_addr   = r_bus_addr;
        w_dout   = r_bus_data_out;
        case (w_next_state)
            T1: begin
                w_strobe[2] = 1'b0;
                w_strobe[1] = w_we;
                w_addr      = w_lat_addr;
                if (w_we) begin
                    w_oe   = 1'b1;
                    w_dout = w_lat_wdata;
                end
            end
            T2, TW, T3: begin
                w_strobe[2] = 1'b0;
                w_addr      = w_lat_addr;
                if (w_we) begin
                    w_strobe[0] = 1'b0;
                    w_oe        = 1'b1;
                    w_dout      = w_lat_wdata;
                end else begin
                    w_strobe[1] = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Command latch and timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_we    <= cmd_we;
            r_addr  <= cmd_addr;
            r_wdata <= cmd_wdata;
            r_err   <= 1'b0;
        end else if (w_abort) begin
            r_err   <= 1'b1;
        end
    end

    // Registered bus outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_strobe       <= STROBE_OFF;
            r_oe           <= 1'b0;
            r_bus_addr     <= '0;
            r_bus_data_out <= '0;
        end else begin
            r_strobe       <= w_strobe;
            r_oe           <= w_oe;
            r_bus_addr     <= w_addr;
            r_bus_data_out <= w_dout;
        end
    end

    // Completion pulse in the IDLE cycle after T3; read data sampled at end of T3
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= (r_state == T3);
            r_rsp_err   <= (r_state == T3) && r_err;
            if ((r_state == T3) && !r_we) begin
                r_rsp_rdata <= bus_data_in;
            end
        end
    end

    assign nMREQ        = r_strobe[2];
    assign nRD          = r_strobe[1];
    assign nWR          = r_strobe[0];
    assign bus_data_oe  = r_oe;
    assign bus_addr     = r_bus_addr;
    assign bus_data_out = r_bus_data_out;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_err      = r_rsp_err;
    assign rsp_rdata    = r_rsp_rdata;

endmodule

// File: doc/z80_bus_master.md
Name: z80_bus_master

Overview:
- Synchronous bus initiator that turns simple command/response transactions into Z80-timed memory cycles (nMREQ/nRD/nWR, T1-T2-Tw-T3) on the CPU-side bus that Z80_MMU translates.
- Lets a loader or DMA engine fill RAM and program MMU page-table entries without the CPU.
- One T-state per clk; the top level builds the tristate from bus_data_out/bus_data_oe.

Parameters:
- ADDR_W, 16, virtual address width.
- DATA_W, 8, data width.
- MAX_WAIT, 15, maximum Tw states before the cycle aborts with an error; range 1..255.

Ports:
- clk  in  1  system clock, one Z80 T-state per cycle.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_we  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  virtual address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data, held until the next read completes.
- rsp_err  out  1  wait timeout; valid with rsp_valid.
- bus_addr  out  ADDR_W  CPU address bus (to MMU cpu_addr).
- bus_data_out  out  DATA_W  write data.
- bus_data_oe  out  1  data bus drive enable.
- bus_data_in  in  DATA_W  read data from the bus.
- nMREQ  out  1  memory request, active low.
- nRD  out  1  read strobe, active low.
- nWR  out  1  write strobe, active low.
- nWAIT  in  1  wait request, active low.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE.
  - nMREQ=nRD=nWR=1.
  - bus_addr=0, bus_data_out=0, bus_data_oe=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - cmd_ready=0 while rst=1.
  - Reset mid-cycle: the transaction is dropped, no rsp_valid is issued, and the strobes are deasserted at the next edge.
- All bus outputs are registered. cmd_ready = (state==IDLE) and !rst.
- IDLE:
  - Strobes high, oe=0.
  - When cmd_valid and cmd_ready: latch we/addr/wdata and go to T1.
- T1:
  - bus_addr=latched addr, nMREQ=0.
  - Read: nRD=0.
  - Write: bus_data_out=wdata, bus_data_oe=1, nWR=1.
  - Next state T2.
- T2:
  - nMREQ=0. Read: nRD=0. Write: nWR=0, oe=1.
  - Sample nWAIT at the end of T2: 0 goes to TW with counter=1; 1 goes to T3.
- TW:
  - Outputs as in T2.
  - nWAIT=1: go to T3.
  - nWAIT=0 and counter==MAX_WAIT: set the error flag and go to T3 (abort).
  - Otherwise increment the counter.
- T3:
  - Outputs as in T2.
  - At the end of T3, a read captures bus_data_in into rsp_rdata. A write leaves rsp_rdata unchanged.
  - Next state IDLE.
- Completion timing:
  - In the first IDLE cycle after T3: rsp_valid=1 and rsp_err=error flag. Both are 0 in every other cycle.
  - The error flag clears on the next accept.
- Strobe timing:
  - Strobes and oe rise to 1/0 in that same IDLE cycle.
  - bus_addr holds its last value in IDLE (no glitch to 0).
- Throughput and latency:
  - Back-to-back: a command can be accepted in the same cycle rsp_valid=1, so a zero-wait cycle takes 4 clks (IDLE, T1, T2, T3).
  - Latency from accept to rsp_valid = 4 + Tw clks.
- Simultaneous events: cmd_valid during a non-IDLE state is ignored (cmd_ready=0), and the command must be held.
- Write data: remains driven for the whole strobe. nWR is never low while oe=0.
- nRD and nWR are never both low.
- A page-table write is an ordinary write. For example, virtual 0x00AC maps through the MMU to physical page 0x000/0xFE region, and the MMU intercepts it. This block does not distinguish it.

Decomposition:
- z80_bus_pkg holds:
  - the state enum (IDLE, T1, T2, TW, T3);
  - ADDR_W/DATA_W defaults;
  - a STROBE_OFF constant {nMREQ,nRD,nWR}=3'b111.
- Sub-module z80_wait_timer is natural: an 8-bit counter with clear/enable and an expired output (counter==MAX_WAIT). It is shared with the future I/O-cycle master.

Test Plan:
- Read, no wait: cmd addr=0x1234, we=0; bus model returns 0x5A with nWAIT=1.
  - nMREQ/nRD low for exactly 3 clks (T1-T3), bus_addr=0x1234.
  - rsp_valid one clk after T3 with rsp_rdata=0x5A and rsp_err=0.
- Write, no wait: addr=0xACFF, wdata=0x7F.
  - oe=1 for 3 clks; nWR low only in T2-T3.
  - bus_data_out=0x7F throughout; rsp_valid=1, rsp_rdata unchanged.
- Wait states: nWAIT=0 for 2 cycles from T2.
  - Exactly 2 TW clks; latency 6.
  - Read data 0xC3 captured at the end of T3.
- Timeout: MAX_WAIT=3, nWAIT held 0.
  - 3 TW clks, then T3, then rsp_valid=1 with rsp_err=1.
  - The next good transaction returns rsp_err=0.
- Back-to-back: cmd_valid held with 3 writes (0x0001..0x0003).
  - Accepted on cycles 0,4,8; nMREQ high for exactly 1 clk between cycles.
- Reset during T2 of a read:
  - The next edge gives strobes=1, oe=0, state IDLE, no rsp_valid.
  - cmd_ready=1 on the first clk after rst falls.
